// File: rtl/text_overlay.sv
// Character-cell text overlay: a 16-slot character buffer rendered into a fixed
// screen box through an external font ROM, two-stage pixel pipeline.
module text_overlay #(
   parameter int ORIGIN_X    = 64,
   parameter int ORIGIN_Y    = 200,
   parameter int SCALE_SHIFT = 2,
   parameter int NUM_CHARS   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic       pix_valid,
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [3:0] wr_char,
   input  logic       clear_req,
   output logic [3:0] font_char,
   output logic [2:0] font_row,
   input  logic [7:0] font_bits,
   output logic       text_on,
   output logic       text_valid,
   output logic       busy
);

   localparam int BOX_W = (NUM_CHARS * 8) << SCALE_SHIFT;
   localparam int BOX_H = 8 << SCALE_SHIFT;
   localparam logic [3:0] SPACE = 4'd4;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t     state, state_nxt;
   logic [3:0] clr_idx, clr_idx_nxt;
   logic [3:0] char_buf [NUM_CHARS];

   logic       in_box;
   logic [3:0] slot;
   logic [2:0] col, row;
   logic       s1_in_box, s1_valid;
   logic [2:0] s1_col;

   // Bounds are compared on the raw coordinates so left/above pixels never wrap into the box.
   always_comb begin
      in_box = pix_valid
            && ({22'd0, pix_x} >= 32'(ORIGIN_X)) && ({22'd0, pix_x} < 32'(ORIGIN_X + BOX_W))
            && ({22'd0, pix_y} >= 32'(ORIGIN_Y)) && ({22'd0, pix_y} < 32'(ORIGIN_Y + BOX_H));
      slot = 4'((pix_x - 10'(ORIGIN_X)) >> (3 + SCALE_SHIFT));
      col  = 3'((pix_x - 10'(ORIGIN_X)) >> SCALE_SHIFT);
      row  = 3'((pix_y - 10'(ORIGIN_Y)) >> SCALE_SHIFT);
   end

   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      case (state)
         IDLE: begin
            if (clear_req) begin
               state_nxt   = CLEAR;
               clr_idx_nxt = 4'd0;
            end
         end
         CLEAR: begin
            clr_idx_nxt = clr_idx + 4'd1;
            if (clr_idx == 4'd15) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == CLEAR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         clr_idx <= 4'd0;
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
      end
   end

   // Host writes are locked out while clearing, and lose to a same-cycle clear request.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CHARS; i++) char_buf[i] <= SPACE;
      end else if (state == CLEAR) begin
         char_buf[clr_idx] <= SPACE;
      end else if (wr_en && !clear_req) begin
         char_buf[wr_addr] <= wr_char;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         font_char  <= SPACE;
         font_row   <= 3'd0;
         s1_col     <= 3'd0;
         s1_in_box  <= 1'b0;
         s1_valid   <= 1'b0;
         text_on    <= 1'b0;
         text_valid <= 1'b0;
      end else begin
         font_char  <= in_box ? char_buf[slot] : SPACE;
         font_row   <= row;
         s1_col     <= col;
         s1_in_box  <= in_box;
         s1_valid   <= pix_valid;
         text_on    <= s1_in_box & font_bits[3'd7 - s1_col];
         text_valid <= s1_valid;
      end
   end

endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay: vector table for the pixel path plus
// hand-written clear / reset-abort / read-during-write sequences.
module tb_text_overlay;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] pix_x, pix_y;
   logic       pix_valid;
   logic       wr_en;
   logic [3:0] wr_addr, wr_char;
   logic       clear_req;
   logic [3:0] font_char;
   logic [2:0] font_row;
   logic [7:0] font_bits;
   logic       text_on, text_valid, busy;

   int total = 0;
   int bad   = 0;

   logic [7:0] rom [16][8];
   assign font_bits = rom[font_char][font_row];

   always #5 clk = ~clk;

   text_overlay dut (
      .clk(clk), .rst(rst),
      .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
      .clear_req(clear_req),
      .font_char(font_char), .font_row(font_row), .font_bits(font_bits),
      .text_on(text_on), .text_valid(text_valid), .busy(busy)
   );

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       v;
      logic [7:0] bits;
      logic [3:0] ec;
      logic [2:0] er;
      logic       eon;
      logic       ev;
   } vec_t;

   vec_t vt[10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic write_slot(input logic [3:0] a, input logic [3:0] c);
      wr_en = 1'b1; wr_addr = a; wr_char = c;
      step();
      wr_en = 1'b0;
   endtask

   task automatic set_pix(input logic [9:0] x, input logic [9:0] y, input logic v);
      pix_x = x; pix_y = y; pix_valid = v;
   endtask

   task automatic check_all_slots(input string name, input logic [3:0] exp);
      for (int i = 0; i < 16; i++) begin
         set_pix(10'(64 + 32 * i), 10'd200, 1'b1);
         step();
         chk($sformatf("%s_slot%0d", name, i), font_char, exp);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_font_char"}, font_char, 4'd4);
      chk({name, "_font_row"}, font_row, 3'd0);
      chk({name, "_text_on"}, text_on, 1'b0);
      chk({name, "_text_valid"}, text_valid, 1'b0);
      chk({name, "_busy"}, busy, 1'b0);
   endtask

   int busy_cnt;

   initial begin
      for (int c = 0; c < 16; c++)
         for (int r = 0; r < 8; r++) rom[c][r] = 8'h00;

      // ---- reset ----
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_char = '0; clear_req = 1'b0;
      set_pix(10'd0, 10'd0, 1'b0);
      step();
      step();
      check_reset_outputs("reset");
      rst = 1'b0;

      // ---- buffer setup: slot0=11, others=1 ----
      write_slot(4'd0, 4'd11);
      for (int i = 1; i < 16; i++) write_slot(4'(i), 4'd1);

      // ---- read-during-write on slot 2 ----
      set_pix(10'd64 + 10'd64, 10'd200, 1'b1);
      wr_en = 1'b1; wr_addr = 4'd2; wr_char = 4'd6;
      step();
      wr_en = 1'b0;
      chk("rdw_old", font_char, 4'd1);
      step();
      chk("rdw_new", font_char, 4'd6);

      // ---- pixel path vectors ----
      vt[0] = '{10'd64,  10'd200, 1'b1, 8'h82, 4'd11, 3'd0, 1'b1, 1'b1};
      vt[1] = '{10'd77,  10'd209, 1'b1, 8'h10, 4'd11, 3'd2, 1'b1, 1'b1};
      vt[2] = '{10'd77,  10'd209, 1'b1, 8'h20, 4'd11, 3'd2, 1'b0, 1'b1};
      vt[3] = '{10'd64,  10'd200, 1'b1, 8'h7F, 4'd11, 3'd0, 1'b0, 1'b1};
      vt[4] = '{10'd63,  10'd200, 1'b1, 8'hFF, 4'd4,  3'd0, 1'b0, 1'b1};
      vt[5] = '{10'd575, 10'd200, 1'b1, 8'h01, 4'd1,  3'd0, 1'b1, 1'b1};
      vt[6] = '{10'd576, 10'd200, 1'b1, 8'hFF, 4'd4,  3'd0, 1'b0, 1'b1};
      vt[7] = '{10'd100, 10'd231, 1'b1, 8'h40, 4'd1,  3'd7, 1'b1, 1'b1};
      vt[8] = '{10'd100, 10'd232, 1'b1, 8'hFF, 4'd4,  3'd0, 1'b0, 1'b1};
      vt[9] = '{10'd100, 10'd210, 1'b0, 8'hFF, 4'd4,  3'd2, 1'b0, 1'b0};

      for (int i = 0; i < 10; i++) begin
         rom[vt[i].ec][vt[i].er] = vt[i].bits;
         set_pix(vt[i].x, vt[i].y, vt[i].v);
         step();
         chk($sformatf("vec%0d_font_char", i), font_char, vt[i].ec);
         chk($sformatf("vec%0d_font_row", i), font_row, vt[i].er);
         step();
         chk($sformatf("vec%0d_text_on", i), text_on, vt[i].eon);
         chk($sformatf("vec%0d_text_valid", i), text_valid, vt[i].ev);
      end

      // ---- clear sequence with blocked write and ignored re-request ----
      for (int i = 0; i < 16; i++) write_slot(4'(i), 4'd7);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      chk("clear_busy_start", busy, 1'b1);
      set_pix(10'd64 + 10'd480, 10'd200, 1'b1);
      wr_en = 1'b1; wr_addr = 4'd5; wr_char = 4'd9;
      busy_cnt = 0;
      while (busy && busy_cnt < 40) begin
         busy_cnt++;
         clear_req = (busy_cnt == 3);
         step();
         if (busy_cnt == 1) chk("clear_live_read_slot15", font_char, 4'd7);
      end
      wr_en = 1'b0;
      clear_req = 1'b0;
      chk("clear_busy_cycles", busy_cnt, 16);
      check_all_slots("after_clear", 4'd4);

      // ---- clear beats same-cycle write, then reset aborts the clear ----
      for (int i = 0; i < 16; i++) write_slot(4'(i), 4'd7);
      clear_req = 1'b1;
      wr_en = 1'b1; wr_addr = 4'd3; wr_char = 4'd9;
      step();
      clear_req = 1'b0;
      wr_en = 1'b0;
      chk("clear_wins_busy", busy, 1'b1);
      set_pix(10'd64 + 10'd96, 10'd200, 1'b1);
      step();
      chk("clear_wins_slot3", font_char, 4'd7);
      for (int i = 0; i < 3; i++) step();
      set_pix(10'd64 + 10'd480, 10'd210, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_outputs("abort");
      check_all_slots("after_abort", 4'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/text_overlay.md
TEXT_OVERLAY -- requirements
Module: text_overlay

Interface
REQ-001 Parameter ORIGIN_X, default 64: screen x of the text box's left edge.
REQ-002 Parameter ORIGIN_Y, default 200: screen y of the text box's top edge.
REQ-003 Parameter SCALE_SHIFT, default 2: each font pixel covers a (1<<SCALE_SHIFT)-square block of screen pixels.
REQ-004 Parameter NUM_CHARS, fixed at 16: length of the character buffer.
REQ-005 Port clk  in  1: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst  in  1: synchronous, active-high reset.
REQ-007 Port pix_x  in  10: current pixel column.
REQ-008 Port pix_y  in  10: current pixel row.
REQ-009 Port pix_valid  in  1: pixel is in the active display area.
REQ-010 Port wr_en  in  1: write strobe for the character buffer.
REQ-011 Port wr_addr  in  4: buffer slot to write.
REQ-012 Port wr_char  in  4: character code to store.
REQ-013 Port clear_req  in  1: single-cycle request to fill the buffer with spaces.
REQ-014 Port font_char  out  4: character code presented to the font ROM.
REQ-015 Port font_row  out  3: row index presented to the font ROM.
REQ-016 Port font_bits  in  8: combinational ROM reply; MSB is the leftmost pixel.
REQ-017 Port text_on  out  1: text foreground pixel.
REQ-018 Port text_valid  out  1: pix_valid delayed to align with text_on.
REQ-019 Port busy  out  1: a clear sequence is in progress.

Function
REQ-020 Box: width 16*8<<SCALE_SHIFT pixels, height 8<<SCALE_SHIFT pixels; in-box SHALL mean ORIGIN_X<=pix_x<ORIGIN_X+width, ORIGIN_Y<=pix_y<ORIGIN_Y+height, and pix_valid=1.
REQ-021 Offsets: dx=pix_x-ORIGIN_X and dy=pix_y-ORIGIN_Y; compare before subtracting, with no wrap-around. Derived fields:
- slot = dx>>(3+SCALE_SHIFT)
- col = (dx>>SCALE_SHIFT)&7
- row = (dy>>SCALE_SHIFT)&7
REQ-022 Stage 1, registered: on each cycle, capture:
- font_char = buffer[slot], or 4 (space) when out of box
- font_row = row
- col, the in-box flag and pix_valid
REQ-023 Stage 2, registered: text_on <= stage-1 in-box AND font_bits[7-col]; text_valid <= stage-1 pix_valid.
REQ-024 Latency: exactly 2 cycles from pix_x/pix_y to the corresponding text_on; throughput is one pixel per cycle with no stalls.
REQ-025 Buffer: 16 x 4-bit entries; a write SHALL take effect on the clock edge where wr_en=1 and busy=0.
REQ-026 Read-during-write: a pixel read of the slot being written SHALL return the old value in that cycle.
REQ-027 FSM states and transitions:
- IDLE -> CLEAR when clear_req=1.
- CLEAR writes 4 into slot clr_idx and increments clr_idx from 0 to 15, one slot per cycle.
- CLEAR -> IDLE after writing slot 15.
REQ-028 busy=1 exactly while in CLEAR: 16 cycles, starting the cycle after clear_req is accepted.
REQ-029 In CLEAR, wr_en SHALL be ignored and clear_req SHALL be ignored (no restart).
REQ-030 Simultaneous clear_req and wr_en in IDLE: the clear SHALL win and the write SHALL be dropped.
REQ-031 The pixel pipeline SHALL keep running during CLEAR, returning each slot's current contents.

Reset
REQ-032 While rst=1, the next edge SHALL set:
- font_char=4, font_row=0
- text_on=0, text_valid=0, busy=0
- FSM=IDLE, clr_idx=0
- all buffer entries=4
REQ-033 Reset during CLEAR SHALL abort the sequence: busy=0 on the following cycle and the buffer fully reset.

Verification
REQ-034 Write slot0=11, then pix=(64,200), pix_valid=1, bench returns font_bits=8'b10000010 for (11,0) -> font_char=11 and font_row=0 one cycle later; text_on=1 and text_valid=1 two cycles later.
REQ-035 Edge checks with a stored row 8'b11111111 -> text_on values:
- pix_x=63 -> 0
- pix_x=64 -> 1
- pix_x=575 -> 1
- pix_x=576 -> 0
- pix_y=231 -> 1
- pix_y=232 -> 0
- pix_valid=0 -> text_on=0, text_valid=0
REQ-036 Column/row mapping: pix=(64+13, 200+9) -> slot 0, col 3, font_row=2; font_bits=8'b00010000 -> text_on=1; font_bits=8'b00100000 -> text_on=0.
REQ-037 clear_req pulse with all slots=7 -> busy high exactly 16 cycles; every slot reads 4 afterwards; wr_en with wr_addr=5, wr_char=9 during busy leaves slot5=4; second clear_req during busy causes no extension.
REQ-038 clear_req and wr_en (slot3=9) in the same cycle -> slot3 ends at 4; rst asserted at clear cycle 6 -> busy=0 next cycle and all outputs at their reset values.
